// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA field positions, opcode constants and loader state encoding
// Purpose: shared definitions for the instruction-memory loader and the opcode
//          legality checker. The CSUM state exists only when LOADER_CHECKSUM_EN
//          is defined.
// Ports:   none (package).
package isa_pkg;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int ALUOP_MSB  = 6;
  localparam int ALUOP_LSB  = 2;

  // Supported opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // Highest ALUop an R-type word may carry
  localparam logic [4:0] ALUOP_MAX = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_WRITE,
    ST_FINISH,
    ST_ERROR
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CSUM
`endif
  } loader_state_e;

endpackage

// File: rtl/isa_opcode_legal.sv
// rtl/isa_opcode_legal.sv - combinational legality check of one instruction word
// Purpose: flags whether a 32-bit word carries a supported opcode (and, for
//          R-type, a supported ALUop).
// Ports:   word_i  - instruction word
//          legal_o - 1 when the word belongs to the supported ISA
import isa_pkg::*;

module isa_opcode_legal (
  input  logic [31:0] word_i,
  output logic        legal_o
);

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       unused_fields;

  assign opcode = word_i[OPCODE_MSB:OPCODE_LSB];
  assign aluop  = word_i[ALUOP_MSB:ALUOP_LSB];
  // Operand fields play no part in legality
  assign unused_fields = ^{word_i[OPCODE_LSB-1:ALUOP_MSB+1], word_i[ALUOP_LSB-1:0]};

  always_comb begin
    legal_o = 1'b0;
    case (opcode)
      OP_RTYPE: legal_o = (aluop <= ALUOP_MAX);
      OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT,
      OP_SW, OP_LW, OP_SETX, OP_BEX: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream program loader into instruction memory
// Purpose: takes a length-prefixed little-endian byte stream, assembles 32-bit
//          words, writes them to imem from address 0, classifies each word and
//          holds the CPU in reset while loading. Optional trailing XOR checksum
//          byte enabled by LOADER_CHECKSUM_EN.
// Ports:   clock, reset_n (async, active-low); start pulse;
//          in_valid/in_data/in_ready byte stream;
//          imem_we/imem_addr/imem_data memory write port;
//          hold_cpu, busy, done, err status; illegal_cnt, first_bad_addr.
import isa_pkg::*;

module imem_program_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              hold_cpu,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic [ADDR_W-1:0] first_bad_addr
);

  // Counter is one bit wider than the address so it can reach 2^ADDR_W
  localparam int          WC_W     = ADDR_W + 1;
  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       n_q, n_d;
  logic [31:0]       word_q, word_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;
  logic [ADDR_W-1:0] first_bad_q, first_bad_d;
  logic [15:0]       len_full;
  logic              word_legal;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  isa_opcode_legal u_legal (
    .word_i  (word_q),
    .legal_o (word_legal)
  );

  assign len_full = {in_data, n_q[7:0]};

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    n_d           = n_q;
    word_d        = word_q;
    word_cnt_d    = word_cnt_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    illegal_cnt_d = illegal_cnt_q;
    first_bad_d   = first_bad_q;
    in_ready      = 1'b0;
    imem_we       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d        = 1'b0;
          err_d         = 1'b0;
          illegal_cnt_d = '0;
          first_bad_d   = '0;
          busy_d        = 1'b1;
          byte_idx_d    = 2'd0;
          word_cnt_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d        = 8'h00;
`endif
          state_d       = ST_LEN;
        end
      end
      ST_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_idx_q == 2'd0) begin
            n_d[7:0]   = in_data;
            byte_idx_d = 2'd1;
          end else begin
            n_d[15:8]  = in_data;
            byte_idx_d = 2'd0;
            if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_FINISH;
`endif
            end else if (32'(len_full) > CAPACITY) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes
          word_d     = {in_data, word_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        if (!word_legal) begin
          if (illegal_cnt_q == '0) first_bad_d = word_cnt_q[ADDR_W-1:0];
          if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
        word_cnt_d = word_cnt_q + 1'b1;
        if (32'(word_cnt_d) == 32'(n_q)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (csum_q == in_data) ? ST_FINISH : ST_ERROR;
      end
`endif
      ST_FINISH, ST_ERROR: state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase

    // Status flags change on entry so they are visible during FINISH/ERROR
    if (state_d == ST_FINISH && state_q != ST_FINISH) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (state_d == ST_ERROR && state_q != ST_ERROR) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= 2'd0;
      n_q           <= '0;
      word_q        <= '0;
      word_cnt_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      illegal_cnt_q <= '0;
      first_bad_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      n_q           <= n_d;
      word_q        <= word_d;
      word_cnt_q    <= word_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      illegal_cnt_q <= illegal_cnt_d;
      first_bad_q   <= first_bad_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign imem_addr      = word_cnt_q[ADDR_W-1:0];
  assign imem_data      = word_q;
  assign hold_cpu       = busy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign illegal_cnt    = illegal_cnt_q;
  assign first_bad_addr = first_bad_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - self-checking bench for imem_program_loader
module tb_imem_program_loader;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              hold_cpu;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  illegal_cnt;
  logic [ADDR_W-1:0] first_bad_addr;

  imem_program_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .hold_cpu       (hold_cpu),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .illegal_cnt    (illegal_cnt),
    .first_bad_addr (first_bad_addr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ISA table
  int legal_ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};

  function automatic bit is_legal(input logic [31:0] w);
    int op;
    op = int'(w[31:27]);
    foreach (legal_ops[i])
      if (op == legal_ops[i]) return (op != 0) || (w[6:2] < 5'd8);
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 3);
    if (r == 0) w[31:27] = 5'(legal_ops[$urandom_range(0, 10)]);
    else if (r == 1) w[31:27] = 5'd0;
    return w;
  endfunction

  // Write monitor
  logic [43:0] wr_q[$];
  time         wr_t[$];
  int          ready_bad = 0;
  time         last_acc_t = 0;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_data});
      wr_t.push_back($time);
      if (in_ready !== 1'b0) ready_bad++;
    end
  end

  task automatic send(input logic [7:0] bytes[$], input int stall_pct, input bit toggle, output bit ok);
    int  budget;
    int  i;
    bit  phase;
    ok     = 1'b1;
    budget = bytes.size() * 20 + 100;
    i      = 0;
    phase  = 1'b0;
    while (i < bytes.size()) begin
      @(negedge clock);
      if (budget == 0) begin
        ok = 1'b0;
        break;
      end
      budget--;
      if (toggle) phase = ~phase;
      if ((toggle && !phase) || (!toggle && ($urandom_range(0, 99) < stall_pct))) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = bytes[i];
        if (in_ready === 1'b1) begin
          @(posedge clock);
          last_acc_t = $time;
          i++;
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                          input int stall_pct, input bit toggle, input bit bad_csum);
    logic [7:0]  bytes[$];
    logic [43:0] exp_wr[$];
    bit          exp_err;
    bit          seen_bad;
    int          exp_ill;
    int          exp_first;
    bit          ok;
    time         t_low;
    logic [7:0]  x;

    $display("run %s n=%0d%s", tag, n, bad_csum ? " corrupted-checksum" : "");
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    exp_err   = (n > (1 << ADDR_W));
    exp_ill   = 0;
    exp_first = 0;
    seen_bad  = 1'b0;
    if (!exp_err) begin
      foreach (words[k]) begin
        for (int b = 0; b < 4; b++) bytes.push_back(words[k][8*b +: 8]);
        exp_wr.push_back({ADDR_W'(k), words[k]});
        if (!is_legal(words[k])) begin
          if (!seen_bad) exp_first = k;
          seen_bad = 1'b1;
          if (exp_ill < (1 << CNT_W) - 1) exp_ill++;
        end
      end
    end
    x = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err) begin
      foreach (bytes[i]) x ^= bytes[i];
      if (bad_csum) begin
        x ^= 8'h5A;
        exp_err = 1'b1;
      end
      bytes.push_back(x);
    end
`endif

    wr_q.delete();
    wr_t.delete();
    ready_bad = 0;
    pulse_start();
    check({tag, ".busy_on"}, busy, 1);
    check({tag, ".hold_on"}, hold_cpu, 1);
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".err_clr"}, err, 0);
    check({tag, ".ill_clr"}, illegal_cnt, 0);
    check({tag, ".first_clr"}, first_bad_addr, 0);

    send(bytes, stall_pct, toggle, ok);
    check({tag, ".send_timeout"}, ok, 1);

    t_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        t_low = $time;
        break;
      end
    end
    check({tag, ".idle_timeout"}, t_low != 0, 1);
    check({tag, ".hold_off"}, hold_cpu, 0);
    check({tag, ".done"}, done, !exp_err);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".ill_cnt"}, illegal_cnt, exp_ill);
    check({tag, ".first_bad"}, first_bad_addr, exp_first);
    check({tag, ".wr_count"}, wr_q.size(), exp_wr.size());
    foreach (exp_wr[k])
      if (k < wr_q.size()) check($sformatf("%s.wr%0d", tag, k), wr_q[k], exp_wr[k]);
    check({tag, ".ready_in_write"}, ready_bad, 0);
`ifndef LOADER_CHECKSUM_EN
    if (exp_wr.size() > 0 && wr_t.size() > 0) begin
      check({tag, ".we_latency"}, wr_t[wr_t.size()-1] - last_acc_t, 5);
      check({tag, ".hold_drop"}, t_low - wr_t[wr_t.size()-1], 10);
    end
`endif
    @(negedge clock);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w[$];
    logic [7:0]  b[$];
    bit          ok;

    #2 reset_n = 1'b0;
    #1;
    check("rst.in_ready", in_ready, 0);
    check("rst.imem_we", imem_we, 0);
    check("rst.imem_addr", imem_addr, 0);
    check("rst.imem_data", imem_data, 0);
    check("rst.hold_cpu", hold_cpu, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.illegal_cnt", illegal_cnt, 0);
    check("rst.first_bad", first_bad_addr, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    w.delete();
    w.push_back(32'h2800_0004);
    w.push_back(32'h0000_0000);
    run_load("basic", 2, w, 0, 1'b0, 1'b0);

    w.delete();
    w.push_back(32'h0000_0000);
    w.push_back(32'hF800_0000);
    w.push_back(32'h0000_0040);
    run_load("illegal", 3, w, 0, 1'b0, 1'b0);

    w.delete();
    run_load("too_long", 32'h1001, w, 0, 1'b0, 1'b0);
    run_load("empty", 0, w, 0, 1'b0, 1'b0);

    w.push_back(32'h3000_0123);
    run_load("toggle", 1, w, 0, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    w.delete();
    w.push_back(32'h0000_0001);
    run_load("csum_good", 1, w, 0, 1'b0, 1'b0);
    run_load("csum_bad", 1, w, 0, 1'b0, 1'b1);
`endif

    // Reset after 6 of 8 data bytes
    wr_q.delete();
    b.delete();
    b.push_back(8'h02); b.push_back(8'h00);
    b.push_back(8'h78); b.push_back(8'h56); b.push_back(8'h34); b.push_back(8'h12);
    b.push_back(8'hEF); b.push_back(8'hBE);
    pulse_start();
    send(b, 0, 1'b0, ok);
    check("midrst.send_timeout", ok, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.hold_cpu", hold_cpu, 0);
    check("midrst.done", done, 0);
    check("midrst.err", err, 0);
    check("midrst.wr_count", wr_q.size(), 1);
    check("midrst.wr0", wr_q[0], {12'h000, 32'h1234_5678});
    @(negedge clock);
    reset_n = 1'b1;
    w.delete();
    w.push_back(32'h1234_5678);
    w.push_back(32'hDEAD_BEEF);
    run_load("after_rst", 2, w, 20, 1'b0, 1'b0);

    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 6);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back(rand_word());
      run_load($sformatf("rand%0d", it), n, w, $urandom_range(0, 60), 1'b0, 1'b0);
    end

    w.delete();
    for (int k = 0; k < 260; k++) w.push_back({5'b11111, 27'($urandom)});
    run_load("saturate", 260, w, 0, 1'b0, 1'b0);

    w.delete();
    for (int k = 0; k < (1 << ADDR_W); k++) w.push_back(rand_word());
    run_load("full", 1 << ADDR_W, w, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
